// File: rtl/lsu_ctrl_if.sv
// Handshake and memory-port bundle for lsu_ctrl: core request/response channel plus
// the single-port word memory. The slave modport is the controller side.
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic [3:0]  mem_mask;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_mask, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_mask, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// RV32I load/store sequencer to a 4096-word single-port memory with byte lanes.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into two memory cycles.
module lsu_ctrl (
  input  logic     clk,
  input  logic     rst_n,
  lsu_ctrl_if.slave bus
);
`ifdef LSU_MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, ACC1 = 2'd2, RESP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, RESP = 2'd3} state_t;
`endif

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [13:0] addr_q;
  logic [31:0] wdata_q;
  logic [11:0] addr_hold_q;
  logic [31:0] wdata_hold_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic        req_ready, rsp_valid, mem_en;
  logic [3:0]  mem_mask;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;

  logic [1:0]  off;
  logic [11:0] wa;
  logic [3:0]  size_mask;
  logic [7:0]  mask8;
  logic        illegal, split, err;
  logic [31:0] data_lo;

  function automatic logic [31:0] load_ext(input logic [63:0] raw, input logic [1:0] sh_b,
                                           input logic [2:0] f3);
    logic [31:0] sh;
    logic        sx;
    sx = 1'b0;
    sh = raw[{sh_b, 3'b000} +: 32];
    case (f3[1:0])
      2'd0: begin
        sx = sh[7] & ~f3[2];
        load_ext = {{24{sx}}, sh[7:0]};
      end
      2'd1: begin
        sx = sh[15] & ~f3[2];
        load_ext = {{16{sx}}, sh[15:0]};
      end
      default: load_ext = sh;
    endcase
  endfunction

  assign off = addr_q[1:0];
  assign wa  = addr_q[13:2];

  always_comb begin
    size_mask = 4'hF;
    case (f3_q[1:0])
      2'd0:    size_mask = 4'h1;
      2'd1:    size_mask = 4'h3;
      default: size_mask = 4'hF;
    endcase
  end

  // Funct3 3/6/7 are not loads; anything above SW is not a store.
  assign illegal = we_q ? (f3_q > 3'd2) : ((f3_q[1:0] == 2'b11) || (f3_q[2:1] == 2'b11));
  assign mask8   = {4'b0000, size_mask} << off;
  assign split   = |mask8[7:4];

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [63:0] data64;
  logic [31:0] data_hi;
  logic [11:0] wa1;
  logic [31:0] rdata_lo_q;
  assign err     = illegal;
  assign data64  = {32'h0, wdata_q} << {off, 3'b000};
  assign data_lo = data64[31:0];
  assign data_hi = data64[63:32];
  assign wa1     = wa + 12'd1;
`else
  assign err     = illegal | split;
  assign data_lo = wdata_q << {off, 3'b000};
`endif

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_en    = 1'b0;
    mem_mask  = 4'h0;
    mem_addr  = addr_hold_q;
    mem_wdata = wdata_hold_q;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) state_d = ACC0;
      end
      ACC0: begin
        mem_addr = wa;
        if (we_q && !err) begin
          mem_en    = 1'b1;
          mem_mask  = mask8[3:0];
          mem_wdata = data_lo;
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        state_d = (split && !err) ? ACC1 : RESP;
`else
        state_d = RESP;
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ACC1: begin
        mem_addr = wa1;
        if (we_q) begin
          mem_en    = 1'b1;
          mem_mask  = mask8[7:4];
          mem_wdata = data_hi;
        end
        state_d = RESP;
      end
`endif
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_hold_q  <= 12'h0;
      wdata_hold_q <= 32'h0;
      rsp_rdata_q  <= 32'h0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_hold_q  <= mem_addr;
      wdata_hold_q <= mem_wdata;
      if (state_q == ACC0 && state_d == RESP) begin
        rsp_err_q   <= err;
        rsp_rdata_q <= (we_q || err) ? 32'h0 : load_ext({32'h0, bus.mem_rdata}, off, f3_q);
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      if (state_q == ACC1) begin
        rsp_err_q   <= 1'b0;
        rsp_rdata_q <= we_q ? 32'h0 : load_ext({bus.mem_rdata, rdata_lo_q}, off, f3_q);
      end
`endif
    end
  end

  // Request and low read word carry no reset: they are only consumed after being loaded.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.req_valid) begin
      we_q    <= bus.req_we;
      f3_q    <= bus.req_funct3;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
`ifdef LSU_MISALIGN_SPLIT_EN
    if (state_q == ACC0) rdata_lo_q <= bus.mem_rdata;
`endif
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_en    = mem_en;
  assign bus.mem_mask  = mem_mask;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vector table, stall and reset sequences,
// then random traffic against a byte-addressed reference memory model.
module tb_lsu_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_ctrl_if bus();
  lsu_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] tbmem [0:4095];
  logic [7:0]  refmem [0:16383];
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [11:0] a;
    logic [3:0]  m;
    logic [31:0] d;
  } wr_t;
  wr_t wr_log[$];

  assign bus.mem_rdata = tbmem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      for (int i = 0; i < 4; i++)
        if (bus.mem_mask[i]) tbmem[bus.mem_addr][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
      wr_log.push_back('{bus.mem_addr, bus.mem_mask, bus.mem_wdata});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit is_split(input logic [2:0] f3, input logic [13:0] addr);
    return (int'(addr[1:0]) + size_of(f3)) > 4;
  endfunction

  function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [13:0] addr);
    bit ill;
    ill = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
`ifdef LSU_MISALIGN_SPLIT_EN
    return ill;
`else
    return ill || is_split(f3, addr);
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [13:0] addr);
    logic [31:0] v;
    logic [63:0] m;
    int n;
    v = 32'h0;
    n = size_of(f3);
    for (int i = 0; i < n; i++)
      v[8*i +: 8] = refmem[(int'(addr) + i) % 16384];
    m = (64'd1 << (8 * n)) - 64'd1;
    if (!f3[2] && v[8*n-1]) v = v | ~m[31:0];
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input int wa);
    return {refmem[4*wa+3], refmem[4*wa+2], refmem[4*wa+1], refmem[4*wa]};
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  task automatic do_txn(input bit we, input logic [2:0] f3, input logic [13:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output bit er,
                        output int lat);
    int guard;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) check("accept_timeout", 32'h0, 32'h1);
    wr_log.delete();
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.rsp_valid) check("rsp_timeout", 32'h0, 32'h1);
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    @(posedge clk);
  endtask

  task automatic run_check(input string tag, input bit we, input logic [2:0] f3,
                           input logic [13:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output bit er);
    wr_t ew[$];
    bit   er_e;
    int   lat, lat_e, n, ba, w;
    logic [31:0] rd_e;
    er_e  = model_err(we, f3, addr);
    lat_e = (!er_e && is_split(f3, addr)) ? 3 : 2;
    rd_e  = (we || er_e) ? 32'h0 : model_load(f3, addr);
    n = size_of(f3);
    if (we && !er_e) begin
      for (int i = 0; i < n; i++) begin
        ba = (int'(addr) + i) % 16384;
        w  = ba / 4;
        if (ew.size() == 0 || ew[ew.size()-1].a != 12'(w)) ew.push_back('{12'(w), 4'h0, 32'h0});
        ew[ew.size()-1].m[ba % 4] = 1'b1;
        ew[ew.size()-1].d[8*(ba % 4) +: 8] = wd[8*i +: 8];
      end
    end
    do_txn(we, f3, addr, wd, rd, er, lat);
    check({tag, "_err"}, {31'h0, er}, {31'h0, er_e});
    check({tag, "_rdata"}, rd, rd_e);
    check({tag, "_lat"}, 32'(lat), 32'(lat_e));
    check({tag, "_nwr"}, 32'(wr_log.size()), 32'(ew.size()));
    for (int i = 0; i < ew.size() && i < wr_log.size(); i++) begin
      check($sformatf("%s_wr%0d_addr", tag, i), {20'h0, wr_log[i].a}, {20'h0, ew[i].a});
      check($sformatf("%s_wr%0d_mask", tag, i), {28'h0, wr_log[i].m}, {28'h0, ew[i].m});
      check($sformatf("%s_wr%0d_data", tag, i), wr_log[i].d & lanes(ew[i].m), ew[i].d);
    end
    if (we && !er_e)
      for (int i = 0; i < n; i++) refmem[(int'(addr) + i) % 16384] = wd[8*i +: 8];
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, {31'h0, bus.req_ready}, 32'h1);
    check({tag, "_rsp_valid"}, {31'h0, bus.rsp_valid}, 32'h0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
    check({tag, "_rsp_err"},   {31'h0, bus.rsp_err}, 32'h0);
    check({tag, "_mem_en"},    {31'h0, bus.mem_en}, 32'h0);
    check({tag, "_mem_mask"},  {28'h0, bus.mem_mask}, 32'h0);
    check({tag, "_mem_addr"},  {20'h0, bus.mem_addr}, 32'h0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
  endtask

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [13:0] addr;
    logic [31:0] wd;
    bit          e_err;
    logic [31:0] e_rd;
  } vec_t;
  vec_t vecs[12];

  initial begin
    logic [31:0] rd, exp_rd;
    bit er;
    int guard, bad;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 14'h0; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4096; i++) tbmem[i] = 32'h0;
    for (int i = 0; i < 16384; i++) refmem[i] = 8'h0;

    vecs[0]  = '{1'b1, 3'd2, 14'h010, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 3'd2, 14'h010, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 3'd0, 14'h013, 32'h000000A5, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 3'd0, 14'h013, 32'h0,        1'b0, 32'hFFFFFFA5};
    vecs[4]  = '{1'b0, 3'd4, 14'h013, 32'h0,        1'b0, 32'h000000A5};
    vecs[6]  = '{1'b0, 3'd3, 14'h020, 32'h0,        1'b1, 32'h0};
    vecs[7]  = '{1'b1, 3'd4, 14'h020, 32'h12345678, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 3'd5, 14'h012, 32'h0,        1'b0, 32'h0000A5AD};
    vecs[11] = '{1'b0, 3'd1, 14'h012, 32'h0,        1'b0, 32'hFFFFA5AD};
`ifdef LSU_MISALIGN_SPLIT_EN
    vecs[5]  = '{1'b0, 3'd1, 14'h003, 32'h0,        1'b0, 32'h0};
    vecs[8]  = '{1'b1, 3'd2, 14'h3FFE, 32'h11223344, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 3'd2, 14'h3FFE, 32'h0,        1'b0, 32'h11223344};
`else
    vecs[5]  = '{1'b0, 3'd1, 14'h003, 32'h0,        1'b1, 32'h0};
    vecs[8]  = '{1'b1, 3'd2, 14'h3FFE, 32'h11223344, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 3'd2, 14'h3FFE, 32'h0,        1'b1, 32'h0};
`endif

    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, rd, er);
      check($sformatf("vec%0d_tbl_err", i), {31'h0, er}, {31'h0, vecs[i].e_err});
      check($sformatf("vec%0d_tbl_rdata", i), rd, vecs[i].e_rd);
    end

    // Stalled response: a competing request must be ignored while RESP holds.
    exp_rd = model_load(3'd2, 14'h010);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = 14'h010;
    @(posedge clk);
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_wdata = 32'h0; bus.req_addr = 14'h010;
    guard = 0;
    while (!bus.rsp_valid && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall%0d_rsp_valid", c), {31'h0, bus.rsp_valid}, 32'h1);
      check($sformatf("stall%0d_rdata", c), bus.rsp_rdata, exp_rd);
      check($sformatf("stall%0d_req_ready", c), {31'h0, bus.req_ready}, 32'h0);
      check($sformatf("stall%0d_mem_en", c), {31'h0, bus.mem_en}, 32'h0);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_release_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("stall_release_req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("stall_ignored_store", tbmem[4], ref_word(4));

    // Reset in the middle of a store access.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd2; bus.req_wdata = 32'hCAFEF00D;
`ifdef LSU_MISALIGN_SPLIT_EN
    bus.req_addr = 14'h0102;
`else
    bus.req_addr = 14'h0100;
`endif
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rst_acc0_mem_en", {31'h0, bus.mem_en}, 32'h1);
`ifdef LSU_MISALIGN_SPLIT_EN
    @(negedge clk);
    check("rst_acc1_mem_en", {31'h0, bus.mem_en}, 32'h1);
    check("rst_acc1_addr", {20'h0, bus.mem_addr}, 32'h41);
    refmem[14'h102] = 8'h0D;
    refmem[14'h103] = 8'hF0;
`endif
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_word40", tbmem[12'h40], ref_word(12'h40));
    check("midrst_word41", tbmem[12'h41], ref_word(12'h41));

    for (int t = 0; t < 300; t++) begin
      logic [13:0] a;
      a = ($urandom_range(0, 3) == 0) ? 14'(16368 + $urandom_range(0, 15)) : 14'($urandom_range(0, 63));
      run_check($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
                $urandom, rd, er);
    end

    bad = 0;
    for (int i = 0; i < 4096; i++) if (tbmem[i] !== ref_word(i)) bad++;
    check("final_mem_words_differing", 32'(bad), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
